// File: rtl/flag_unit.sv
// Z/V/N flag producer for branch resolution: registers flags from the EX result
// per opcode class and interlocks a conditional branch in ID on a pending flag write.
module flag_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_hold,
  input  logic             ex_flush,
  input  logic [3:0]       ex_opcode,
  input  logic [15:0]      ex_result,
  input  logic             ex_ovfl,
  input  logic             id_branch,
  input  logic [2:0]       id_ccc,
  output logic [2:0]       F,
  output logic             flag_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [2:0]       f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_zvn, wr_z, wr_any, we, hz;

  // Opcode class decode: ADD/SUB write all flags, logic/shift ops write Z only.
  always_comb begin
    wr_zvn = 1'b0;
    wr_z   = 1'b0;
    case (ex_opcode)
      4'b0000, 4'b0001:                   wr_zvn = 1'b1;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_z   = 1'b1;
      default: ;
    endcase
  end

  assign wr_any = wr_zvn | wr_z;
  assign we     = ex_valid & ~ex_hold & ~ex_flush & wr_any;
  assign hz     = id_branch & (id_ccc != 3'b111) & ex_valid & ~ex_flush & wr_any;

  always_comb begin
    f_d = f_q;
    if (we) begin
      f_d[2] = (ex_result == 16'h0000);
      if (wr_zvn) begin
        f_d[1] = ex_ovfl;
        f_d[0] = ex_result[15];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A held producer keeps the FSM in idle so each held cycle adds one stall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = (hz && !ex_hold) ? StWait : StIdle;
      StWait:  state_d = hz ? StWait : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Gated by rst so an asserted reset drops the stall before any clock edge.
  always_comb begin
    flag_stall = 1'b0;
    unique case (state_q)
      StIdle:  flag_stall = hz & ~rst;
      StWait:  flag_stall = hz & ~rst;
      default: flag_stall = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flag_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q   <= 3'b000;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign F         = f_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit: flag classes, interlock, hold/flush,
// asynchronous reset and stall counter saturation.
module tb_flag_unit;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpLw  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_hold, ex_flush, ex_ovfl, id_branch;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic [2:0]  id_ccc;
  logic [2:0]  F;
  logic        flag_stall;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_bad = 0;

  flag_unit #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_hold    (ex_hold),
    .ex_flush   (ex_flush),
    .ex_opcode  (ex_opcode),
    .ex_result  (ex_result),
    .ex_ovfl    (ex_ovfl),
    .id_branch  (id_branch),
    .id_ccc     (id_ccc),
    .F          (F),
    .flag_stall (flag_stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    ex_hold   = 1'b0;
    ex_flush  = 1'b0;
    ex_opcode = OpLw;
    ex_result = 16'h0000;
    ex_ovfl   = 1'b0;
    id_branch = 1'b0;
    id_ccc    = 3'b000;
  endtask

  task automatic ex_op(input logic [3:0] op, input logic [15:0] res, input logic ov);
    ex_valid  = 1'b1;
    ex_opcode = op;
    ex_result = res;
    ex_ovfl   = ov;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("reset_F", 32'(F), 32'h0);
    check("reset_stall", 32'(flag_stall), 32'h0);
    check("reset_cnt", 32'(stall_cnt), 32'h0);
    rst = 1'b0;
    step();

    // Flag classes.
    ex_op(OpSub, 16'h0000, 1'b0); step();
    check("sub_zero", 32'(F), 32'h4);
    ex_op(OpAdd, 16'h8000, 1'b1); step();
    check("add_neg_ovf", 32'(F), 32'h3);
    ex_op(OpXor, 16'h0000, 1'b0); step();
    check("xor_z_only", 32'(F), 32'h7);
    ex_op(OpSll, 16'h0004, 1'b1); step();
    check("sll_z_only", 32'(F), 32'h3);
    ex_op(OpLw, 16'h0000, 1'b1); step();
    check("lw_no_write", 32'(F), 32'h3);
    ex_op(OpAdd, 16'h0000, 1'b0); ex_valid = 1'b0; step();
    check("bubble_no_write", 32'(F), 32'h3);
    ex_op(OpXor, 16'h0000, 1'b0); #1;
    check("producer_no_branch_stall", 32'(flag_stall), 32'h0);
    step();
    check("xor_set_z", 32'(F), 32'h7);

    // Mid-cycle reset during a held stall with F=111.
    ex_op(OpAdd, 16'h0001, 1'b0); ex_hold = 1'b1; id_branch = 1'b1; id_ccc = 3'b001;
    step();
    step();
    check("held_stall", 32'(flag_stall), 32'h1);
    check("held_cnt", 32'(stall_cnt), 32'h2);
    check("held_no_write", 32'(F), 32'h7);
    #1 rst = 1'b1;
    #1;
    check("async_rst_F", 32'(F), 32'h0);
    check("async_rst_stall", 32'(flag_stall), 32'h0);
    check("async_rst_cnt", 32'(stall_cnt), 32'h0);
    idle_inputs();
    #2 rst = 1'b0;
    step();

    // Interlock: one stall cycle, then the branch sees committed flags.
    ex_op(OpAdd, 16'h0000, 1'b0); id_branch = 1'b1; id_ccc = 3'b001; #1;
    check("hz_stall", 32'(flag_stall), 32'h1);
    step();
    check("hz_cnt", 32'(stall_cnt), 32'h1);
    check("hz_F", 32'(F), 32'h4);
    ex_valid = 1'b0; #1;
    check("hz_released", 32'(flag_stall), 32'h0);
    step();
    check("hz_cnt_stable", 32'(stall_cnt), 32'h1);
    ex_op(OpSub, 16'h8000, 1'b1); id_ccc = 3'b111; #1;
    check("uncond_no_stall", 32'(flag_stall), 32'h0);
    step();
    check("uncond_cnt", 32'(stall_cnt), 32'h1);
    check("uncond_F", 32'(F), 32'h3);

    // Hold for two cycles: three stall cycles, write only when hold drops.
    ex_op(OpAdd, 16'h0001, 1'b0); id_ccc = 3'b010; ex_hold = 1'b1; #1;
    check("hold_stall_1", 32'(flag_stall), 32'h1);
    step();
    check("hold_F_1", 32'(F), 32'h3);
    #1 check("hold_stall_2", 32'(flag_stall), 32'h1);
    step();
    check("hold_F_2", 32'(F), 32'h3);
    ex_hold = 1'b0; #1;
    check("hold_stall_3", 32'(flag_stall), 32'h1);
    step();
    check("hold_F_written", 32'(F), 32'h0);
    check("hold_cnt", 32'(stall_cnt), 32'h4);
    ex_op(OpSub, 16'h0000, 1'b0); #1;
    check("wait_back_to_back", 32'(flag_stall), 32'h1);
    step();
    check("b2b_cnt", 32'(stall_cnt), 32'h5);
    check("b2b_F", 32'(F), 32'h4);

    // Flush removes both the write and the hazard.
    ex_op(OpAdd, 16'h8001, 1'b1); ex_flush = 1'b1; #1;
    check("flush_no_stall", 32'(flag_stall), 32'h0);
    step();
    check("flush_F", 32'(F), 32'h4);
    check("flush_cnt", 32'(stall_cnt), 32'h5);

    // Saturation: reset counter, run to FFFE with a held hazard, then 3 more.
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    ex_op(OpAdd, 16'h0001, 1'b0); ex_hold = 1'b1; id_branch = 1'b1; id_ccc = 3'b001;
    for (int i = 0; i < 65534; i++) step();
    check("sat_preload", 32'(stall_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sat_hold", 32'(stall_cnt), 32'hFFFF);
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
